// File: rtl/vregfile_wbarb.sv
// Writeback arbiter: merges the non-stallable ALU stream (A) and the buffered
// load-return stream (B) onto the single vector register file write port.
module vregfile_wbarb #(
   parameter int WIDTH         = 32,
   parameter int LOG2NUMREGS   = 5,
   parameter int FIFODEPTH     = 4,
   parameter int LOG2FIFODEPTH = 2,
   parameter int STARVE_LIMIT  = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     a_valid,
   input  logic [LOG2NUMREGS-1:0]   a_reg,
   input  logic [WIDTH-1:0]         a_data,
   input  logic [WIDTH/8-1:0]       a_byteen,
   output logic                     a_stall,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [LOG2NUMREGS-1:0]   b_reg,
   input  logic [WIDTH-1:0]         b_data,
   input  logic [WIDTH/8-1:0]       b_byteen,
   input  logic [LOG2NUMREGS-1:0]   lookup_reg,
   output logic                     lookup_hit,
   output logic [LOG2NUMREGS-1:0]   c_reg,
   output logic [WIDTH-1:0]         c_writedatain,
   output logic [WIDTH/8-1:0]       c_byteen,
   output logic                     c_we
);
   localparam int BEW = WIDTH / 8;
   localparam int SCW = $clog2(STARVE_LIMIT + 1);
   localparam logic [LOG2FIFODEPTH:0] FULL_CNT = (LOG2FIFODEPTH + 1)'(FIFODEPTH);
   localparam logic [SCW-1:0]         LIMIT    = SCW'(STARVE_LIMIT);

   logic [LOG2NUMREGS-1:0] mem_reg    [FIFODEPTH];
   logic [WIDTH-1:0]       mem_data   [FIFODEPTH];
   logic [BEW-1:0]         mem_byteen [FIFODEPTH];

   logic [LOG2FIFODEPTH-1:0] rd_ptr, wr_ptr;
   logic [LOG2FIFODEPTH:0]   count;
   logic [SCW-1:0]           starve_cnt, starve_nxt;
   logic                     a_stall_nxt;
   logic                     fifo_empty, push, pop;

   logic                   win_valid;
   logic [LOG2NUMREGS-1:0] win_reg;
   logic [WIDTH-1:0]       win_data;
   logic [BEW-1:0]         win_byteen;

   assign fifo_empty = (count == '0);
   // Gated by resetn so the FIFO looks unavailable for the whole reset window.
   assign b_ready    = resetn && (count != FULL_CNT);
   assign push       = b_valid && b_ready;
   assign pop        = !a_valid && !fifo_empty;

   always_comb begin
      win_valid  = 1'b0;
      win_reg    = '0;
      win_data   = '0;
      win_byteen = '0;
      if (a_valid) begin
         win_valid  = 1'b1;
         win_reg    = a_reg;
         win_data   = a_data;
         win_byteen = a_byteen;
      end else if (!fifo_empty) begin
         win_valid  = 1'b1;
         win_reg    = mem_reg[rd_ptr];
         win_data   = mem_data[rd_ptr];
         win_byteen = mem_byteen[rd_ptr];
      end
   end

   always_comb begin
      if (pop || fifo_empty)
         starve_nxt = '0;
      else if (a_valid && (starve_cnt != LIMIT))
         starve_nxt = starve_cnt + 1'b1;
      else
         starve_nxt = starve_cnt;

      if (pop)
         a_stall_nxt = 1'b0;
      else if (starve_nxt == LIMIT)
         a_stall_nxt = 1'b1;
      else
         a_stall_nxt = a_stall;
   end

   // An entry is live when its distance from the read pointer is below count.
   always_comb begin
      lookup_hit = 1'b0;
      if (resetn) begin
         for (int unsigned i = 0; i < FIFODEPTH; i++) begin
            if (({1'b0, LOG2FIFODEPTH'(i) - rd_ptr} < count) &&
                (mem_reg[LOG2FIFODEPTH'(i)] == lookup_reg))
               lookup_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr]    <= b_reg;
         mem_data[wr_ptr]   <= b_data;
         mem_byteen[wr_ptr] <= b_byteen;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         starve_cnt    <= '0;
         a_stall       <= 1'b0;
         c_we          <= 1'b0;
         c_reg         <= '0;
         c_writedatain <= '0;
         c_byteen      <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         starve_cnt    <= starve_nxt;
         a_stall       <= a_stall_nxt;
         c_we          <= win_valid && (win_byteen != '0);
         c_reg         <= win_reg;
         c_writedatain <= win_data;
         c_byteen      <= win_byteen;
      end
   end
endmodule

// File: tb/tb_vregfile_wbarb.sv
// Scoreboard bench for vregfile_wbarb: stimulus queues expected writes per
// source, a negedge monitor pops and compares whenever the write port fires.
module tb_vregfile_wbarb;
   logic        clk;
   logic        resetn;
   logic        a_valid;
   logic [4:0]  a_reg;
   logic [31:0] a_data;
   logic [3:0]  a_byteen;
   logic        a_stall;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_reg;
   logic [31:0] b_data;
   logic [3:0]  b_byteen;
   logic [4:0]  lookup_reg;
   logic        lookup_hit;
   logic [4:0]  c_reg;
   logic [31:0] c_writedatain;
   logic [3:0]  c_byteen;
   logic        c_we;

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
      logic [3:0]  be;
   } wb_t;

   wb_t exp_a[$];
   wb_t exp_b[$];
   wb_t mon_e;
   int  n_pass  = 0;
   int  n_total = 0;
   int  occ     = 0;
   int  nb;
   logic prev_a = 1'b0;

   vregfile_wbarb #(
      .WIDTH(32), .LOG2NUMREGS(5), .FIFODEPTH(4), .LOG2FIFODEPTH(2), .STARVE_LIMIT(8)
   ) dut (
      .clk(clk), .resetn(resetn),
      .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_byteen(a_byteen),
      .a_stall(a_stall),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .b_byteen(b_byteen),
      .lookup_reg(lookup_reg), .lookup_hit(lookup_hit),
      .c_reg(c_reg), .c_writedatain(c_writedatain), .c_byteen(c_byteen), .c_we(c_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Negedge of the current cycle: check b_ready against the occupancy model and
   // queue the writes this cycle's inputs will produce.
   task automatic sample();
      logic hs, pop_m;
      @(negedge clk);
      check("b_ready", b_ready, resetn ? (occ != 4) : 1'b0);
      hs    = resetn && b_valid && b_ready;
      pop_m = resetn && !a_valid && (occ != 0);
      if (resetn && a_valid) exp_a.push_back(wb_t'{r: a_reg, d: a_data, be: a_byteen});
      if (hs && (b_byteen != 4'h0)) exp_b.push_back(wb_t'{r: b_reg, d: b_data, be: b_byteen});
      if (!resetn) occ = 0;
      else occ = occ + int'(hs) - int'(pop_m);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (prev_a) begin
         if (exp_a.size() == 0) begin
            n_total++;
            $display("FAIL wb_a: got c_we=%b expected no A write queued", c_we);
         end else begin
            mon_e = exp_a.pop_front();
            check("wb_a", {c_we, c_reg, c_writedatain, c_byteen},
                  {(mon_e.be != 4'h0), mon_e.r, mon_e.d, mon_e.be});
         end
      end else if (c_we === 1'b1) begin
         if (exp_b.size() == 0) begin
            n_total++;
            $display("FAIL wb_b: got write reg=%0d data=%h expected none", c_reg, c_writedatain);
         end else begin
            mon_e = exp_b.pop_front();
            check("wb_b", {c_reg, c_writedatain, c_byteen}, {mon_e.r, mon_e.d, mon_e.be});
         end
      end
      prev_a = resetn && a_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; idle();
      a_reg = '0; a_data = '0; a_byteen = '0;
      b_reg = 5'd7; b_data = '0; b_byteen = 4'hF; lookup_reg = 5'd7;
      b_valid = 1'b1;
      advance();
      sample();
      check("rst_c_we", c_we, 0);
      check("rst_c_reg", c_reg, 0);
      check("rst_c_data", c_writedatain, 0);
      check("rst_c_byteen", c_byteen, 0);
      check("rst_a_stall", a_stall, 0);
      check("rst_lookup_hit", lookup_hit, 0);
      advance();

      // Single ALU write
      resetn = 1'b1; b_valid = 1'b0;
      a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hDEADBEEF; a_byteen = 4'hF;
      sample(); advance();
      idle();
      sample();
      check("a_lat_we", c_we, 1);
      check("a_lat_reg", c_reg, 3);
      check("a_lat_data", c_writedatain, 32'hDEADBEEF);
      advance();

      // Single load write, 2-cycle latency, one-cycle lookup visibility
      b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h11; b_byteen = 4'hF; lookup_reg = 5'd7;
      sample(); check("b_hit_t0", lookup_hit, 0); advance();
      idle();
      sample(); check("b_hit_t1", lookup_hit, 1); check("b_we_t1", c_we, 0); advance();
      sample(); check("b_hit_t2", lookup_hit, 0); check("b_we_t2", c_we, 1);
      check("b_reg_t2", c_reg, 7); advance();

      // Fill under continuous A, starvation stall, then ordered drain
      nb = 0;
      for (int i = 0; i < 10; i++) begin
         a_valid = 1'b1; a_reg = 5'(i); a_data = 32'hA3000000 + i; a_byteen = 4'hF;
         b_valid = (nb < 4); b_reg = 5'(10 + nb); b_data = 32'hB0 + nb; b_byteen = 4'hF;
         sample();
         check("stall_rise", a_stall, (i == 9));
         if (b_valid && b_ready) nb++;
         advance();
      end
      for (int i = 10; i < 15; i++) begin
         idle();
         sample();
         check("stall_clear", a_stall, (i == 10));
         if (i >= 11) check("drain_we", c_we, 1);
         advance();
      end

      // Mixed traffic, A idle every 3rd cycle
      for (int i = 0; i < 20; i++) begin
         a_valid = (i % 3 != 2); a_reg = 5'(i); a_data = 32'hA4000000 + i;
         a_byteen = (i == 7) ? 4'h0 : 4'hF;
         b_valid = 1'b1; b_reg = 5'((i + 5) % 32); b_data = 32'hB4000000 + i;
         b_byteen = 4'((i % 15) + 1);
         sample(); advance();
      end
      for (int i = 0; i < 8; i++) begin
         idle(); sample(); advance();
      end
      check("mix_a_drained", exp_a.size(), 0);
      check("mix_b_drained", exp_b.size(), 0);

      // Zero-byteen load pops without writing
      b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h55; b_byteen = 4'h0; lookup_reg = 5'd9;
      sample(); check("z_hit_t0", lookup_hit, 0); advance();
      idle();
      sample(); check("z_hit_t1", lookup_hit, 1); advance();
      sample(); check("z_hit_t2", lookup_hit, 0); check("z_we_t2", c_we, 0); advance();

      // Reset with three buffered loads
      for (int i = 0; i < 3; i++) begin
         a_valid = 1'b1; a_reg = 5'd1; a_data = 32'hA6000000 + i; a_byteen = 4'hF;
         b_valid = 1'b1; b_reg = 5'(20 + i); b_data = 32'hB6000000 + i; b_byteen = 4'hF;
         sample(); advance();
      end
      idle(); resetn = 1'b0; lookup_reg = 5'd20;
      sample(); check("mid_rst_hit", lookup_hit, 0);
      exp_b.delete();
      advance();
      resetn = 1'b1;
      for (int r = 0; r < 32; r++) begin
         lookup_reg = 5'(r);
         sample();
         check("post_rst_hit", lookup_hit, 0);
         check("post_rst_we", c_we, 0);
         advance();
      end
      check("end_a_empty", exp_a.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
